load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the ALU and the word-organised data memory. Takes an ALU-computed address plus store data and returns load data to the write-back stage.
- Converts byte, halfword and word requests into word-addressed memory strobes with byte enables.
- Performs sign or zero extension on loads.
- Splits accesses that cross a word boundary into two sequential word transactions, under a state machine with a valid/ready request handshake.

Parameters:
- MEM_WORDS, 1024: data-memory depth in words. mem_addr wraps modulo 2^30; MEM_WORDS is only used for the bench model.

Ports:
- clk in 1: single clock, rising edge.
- rst_n in 1: reset, asynchronous, active-low.
- req_valid in 1: request present.
- req_ready out 1: unit idle, request accepted on this edge if req_valid.
- req_write in 1: 1 = store, 0 = load.
- req_size in 2: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_signed in 1: sign-extend the load result.
- req_addr in 32: byte address (aluResult).
- req_wdata in 32: store data (writeDataMem), low bytes used for byte/half.
- resp_valid out 1: one-cycle completion pulse, for both loads and stores.
- resp_rdata out 32: extended load data; 0 for stores and errors.
- access_err out 1: qualifies resp_valid; illegal or unsupported access.
- mem_addr out 30: word address.
- mem_wdata out 32: lane-aligned store data.
- mem_be out 4: byte enables; bit k = bits 8k+7:8k (little-endian).
- mem_read out 1: read strobe.
- mem_write out 1: write strobe.
- mem_rdata in 32: read data, valid the cycle after mem_read.

Behaviour:
- Reset values:
  - State IDLE, req_ready = 1.
  - resp_valid, access_err, mem_read, mem_write = 0.
  - mem_addr, mem_wdata, mem_be, resp_rdata = 0.
- FSM states and transitions:
  - IDLE: req_ready = 1. On req_valid, latch all request fields; go to ISSUE0 (or ERR).
  - ISSUE0: assert one strobe for word req_addr[31:2]. Go to ISSUE1 if split, else CAPT.
  - ISSUE1: assert strobe for word req_addr[31:2]+1, wrapping 0x3FFFFFFF to 0. Capture first mem_rdata. Go to CAPT.
  - CAPT: capture last mem_rdata. Go to RESP.
  - RESP: resp_valid = 1 for one cycle. Go to IDLE.
  - ERR: resp_valid = 1 and access_err = 1, no memory strobes. Go to IDLE.
- req_ready = 0 in every state except IDLE. No queuing.
- mem_read and mem_write are never both high. All mem_* outputs are 0 when no strobe is asserted.
- Latency (request accepted at edge of cycle N):
  - Aligned access: strobe in cycle N+1, resp_valid in cycle N+3.
  - Split access: strobes in cycles N+1 and N+2, resp_valid in cycle N+4.
  - ERR: resp_valid in cycle N+2.
- Definitions: off = req_addr[1:0]; bytes = 1, 2 or 4 by size. The access is a crossing access when off + bytes > 4.
- Store lanes:
  - First word: mem_be = byte mask << off; mem_wdata = wdata << 8*off.
  - Second word: mem_be = remaining low lanes; mem_wdata = wdata >> 8*(4-off).
- Load extraction:
  - Form {second, first} >> 8*off and take the low `bytes` bytes.
  - Extend from bit 8*bytes-1 if req_signed, else zero-extend. Word loads ignore req_signed.
- req_size = 11 always goes to ERR.
- Reset mid-operation: strobes drop immediately (asynchronous) and no response is issued. A split store interrupted after ISSUE0 leaves the first word written; this is accepted and documented.
- req_valid asserted while busy is ignored. The requester must hold it until req_ready.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: crossing accesses are split as above, and access_err is only raised for size 11.
- Undefined: crossing accesses go to ERR (access_err = 1, resp_rdata = 0, no strobes), ISSUE1 is unreachable, and split logic is not compiled.

Decomposition:
- lsu_pkg holds:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD;
  - FSM state encodings IDLE, ISSUE0, ISSUE1, CAPT, RESP, ERR;
  - byte-mask constants.
- One combinational sub-module, lsu_align, does store lane shifting/byte-enable generation and load extraction/extension. It is instantiated once; the FSM and latches stay in load_store_unit.

Test Plan:
- Reset: hold rst_n = 0 with req_valid = 1 -> req_ready = 1, all strobes 0, resp_valid never asserted.
- Word store to 0x100 with data 0xDEADBEEF accepted at N -> cycle N+1: mem_write = 1, mem_addr = 0x40, mem_be = 1111, mem_wdata = 0xDEADBEEF. Then a word load from 0x100 -> resp_rdata = 0xDEADBEEF at N+3.
- Word 0x40 = 0x80FF0000:
  - signed byte load 0x103 -> 0xFFFFFF80;
  - unsigned byte load 0x103 -> 0x00000080;
  - signed half load 0x102 -> 0xFFFF80FF.
- Split word load at 0x102, with word 0x40 = 0x44332211 and word 0x41 = 0x88776655 -> reads at 0x40 then 0x41, resp_rdata = 0x66554433 at N+4. With the macro undefined -> access_err = 1 at N+2, no strobes.
- Split half store 0xABCD at 0x7 -> word 0x1: be 1000, wdata 0xCD000000. Word 0x2: be 0001, wdata 0x000000AB. Word load at 0xFFFFFFFE -> second strobe at mem_addr 0.
- Pull rst_n low during ISSUE1 of a split store -> strobes drop immediately, no resp_valid, word 0x1 already written; after release req_ready = 1. Size 11 request -> ERR pulse at N+2.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, byte masks.
// Split-access support is selected by LSU_MISALIGN_SPLIT_EN in the units that import this.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
        ISSUE1 = 3'd2,
        CAPT   = 3'd3,
        RESP   = 3'd4,
        ERR    = 3'd5
    } state_e;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic [3:0] size_mask(size_e size);
        case (size)
            SIZE_BYTE: return BE_BYTE;
            SIZE_HALF: return BE_HALF;
            SIZE_WORD: return BE_WORD;
            default:   return BE_NONE;
        endcase
    endfunction

    // True when the access spills past the end of its first word.
    function automatic logic is_crossing(size_e size, logic [1:0] off);
        case (size)
            SIZE_HALF: return off == 2'd3;
            SIZE_WORD: return off != 2'd0;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / data per word, load extraction and extension.
// Second-word lanes exist only when LSU_MISALIGN_SPLIT_EN is defined.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  off_i,
    input  logic        signed_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_lo_i,
    input  logic [31:0] ld_hi_i,
    output logic [3:0]  be0_o,
    output logic [3:0]  be1_o,
    output logic [31:0] wdata0_o,
    output logic [31:0] wdata1_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  be_wide;
    logic [63:0] wdata_wide;
    logic [63:0] ld_wide;
    logic [4:0]  shamt;
    logic        unused_align;

    always_comb begin
        shamt      = {off_i, 3'b000};
        be_wide    = {4'b0000, size_mask(size_i)} << off_i;
        wdata_wide = {32'h0, st_data_i} << shamt;
        be0_o      = be_wide[3:0];
        wdata0_o   = wdata_wide[31:0];
`ifdef LSU_MISALIGN_SPLIT_EN
        be1_o      = be_wide[7:4];
        wdata1_o   = wdata_wide[63:32];
        ld_wide    = {ld_hi_i, ld_lo_i} >> shamt;
`else
        be1_o      = BE_NONE;
        wdata1_o   = 32'h0;
        ld_wide    = {32'h0, ld_lo_i} >> shamt;
`endif
        case (size_i)
            SIZE_BYTE: ld_data_o = {{24{signed_i & ld_wide[7]}}, ld_wide[7:0]};
            SIZE_HALF: ld_data_o = {{16{signed_i & ld_wide[15]}}, ld_wide[15:0]};
            default:   ld_data_o = ld_wide[31:0];
        endcase
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    assign unused_align = ^ld_wide[63:32];
`else
    assign unused_align = ^{ld_wide[63:32], be_wide[7:4], wdata_wide[63:32], ld_hi_i};
`endif

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: request handshake FSM turning byte/half/word accesses into word strobes.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses instead of rejecting them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        access_err_o,
    output logic [29:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    input  logic [31:0] mem_rdata_i
);

    state_e      state_q, state_d;
    logic        write_q, signed_q;
    size_e       size_q;
    logic [31:0] addr_q, wdata_q;
    logic        lat_en;
    logic        resp_valid_q, access_err_q;
    logic [31:0] resp_rdata_q;
    logic [3:0]  be0, be1;
    logic [31:0] wdata0, wdata1, ld_data;
    logic [31:0] ld_lo, ld_hi;
    logic        unused_mem_words;

    assign unused_mem_words = ^MEM_WORDS;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        split_q;
    logic [31:0] rdata0_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            split_q  <= 1'b0;
            rdata0_q <= 32'h0;
        end else begin
            if (lat_en) begin
                split_q <= is_crossing(size_e'(req_size_i), req_addr_i[1:0]);
            end
            if (state_q == ISSUE1) begin
                rdata0_q <= mem_rdata_i;
            end
        end
    end

    assign ld_lo = split_q ? rdata0_q : mem_rdata_i;
    assign ld_hi = split_q ? mem_rdata_i : 32'h0;
`else
    assign ld_lo = mem_rdata_i;
    assign ld_hi = 32'h0;
`endif

    lsu_align u_align (
        .size_i    (size_q),
        .off_i     (addr_q[1:0]),
        .signed_i  (signed_q),
        .st_data_i (wdata_q),
        .ld_lo_i   (ld_lo),
        .ld_hi_i   (ld_hi),
        .be0_o     (be0),
        .be1_o     (be1),
        .wdata0_o  (wdata0),
        .wdata1_o  (wdata1),
        .ld_data_o (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        lat_en      = 1'b0;
        req_ready_o = 1'b0;
        mem_addr_o  = 30'h0;
        mem_wdata_o = 32'h0;
        mem_be_o    = 4'h0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    lat_en = 1'b1;
                    if (size_e'(req_size_i) == SIZE_RSVD) begin
                        state_d = ERR;
`ifndef LSU_MISALIGN_SPLIT_EN
                    end else if (is_crossing(size_e'(req_size_i), req_addr_i[1:0])) begin
                        state_d = ERR;
`endif
                    end else begin
                        state_d = ISSUE0;
                    end
                end
            end
            ISSUE0: begin
                mem_addr_o  = addr_q[31:2];
                mem_be_o    = be0;
                mem_read_o  = !write_q;
                mem_write_o = write_q;
                mem_wdata_o = write_q ? wdata0 : 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
                state_d     = split_q ? ISSUE1 : CAPT;
`else
                state_d     = CAPT;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ISSUE1: begin
                mem_addr_o  = addr_q[31:2] + 30'd1;
                mem_be_o    = be1;
                mem_read_o  = !write_q;
                mem_write_o = write_q;
                mem_wdata_o = write_q ? wdata1 : 32'h0;
                state_d     = CAPT;
            end
`endif
            CAPT:    state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response registers load on leaving CAPT/ERR, so the pulse lands in RESP (or just after ERR).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= SIZE_BYTE;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            access_err_q <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= (state_q == CAPT) || (state_q == ERR);
            access_err_q <= (state_q == ERR);
            resp_rdata_q <= (state_q == CAPT && !write_q) ? ld_data : 32'h0;
            if (lat_en) begin
                write_q  <= req_write_i;
                signed_q <= req_signed_i;
                size_q   <= size_e'(req_size_i);
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
            end
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign access_err_o = access_err_q;
    assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-enabled word memory model.
module tb_load_store_unit;

    localparam int unsigned MEM_WORDS = 1024;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, access_err;
    logic [31:0] resp_rdata;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_read, mem_write;

    logic [31:0] mem [0:MEM_WORDS-1];
    logic        pre_we;
    int          pre_idx;
    logic [31:0] pre_data;

    int n_cmp = 0;
    int n_err = 0;
    int resp_cnt = 0;

    logic [29:0] rec_addr  [1:8];
    logic [31:0] rec_wdata [1:8];
    logic [3:0]  rec_be    [1:8];
    logic        rec_read  [1:8];
    logic        rec_write [1:8];
    logic        rec_ready [1:8];

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_size_i   (req_size),
        .req_signed_i (req_signed),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .access_err_o (access_err),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_be_o     (mem_be),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (mem_write) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_be[k]) mem[int'(mem_addr % MEM_WORDS)][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
        end
        if (mem_read) mem_rdata <= mem[int'(mem_addr % MEM_WORDS)];
    end

    always @(negedge clk) if (resp_valid) resp_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check_eq("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic send(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd);
        wait_ready();
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Runs one request; records cycles N+1..N+lat and checks the response at N+lat.
    task automatic txn(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, input int lat,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int early = 0;
        send(wr, sz, sg, addr, wd);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            rec_addr[i] = mem_addr;  rec_wdata[i] = mem_wdata; rec_be[i] = mem_be;
            rec_read[i] = mem_read;  rec_write[i] = mem_write; rec_ready[i] = req_ready;
            if (i < lat && resp_valid) early++;
        end
        check_eq({tag, ".early"}, 32'(early), 32'd0);
        check_eq({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        check_eq({tag, ".rdata"}, resp_rdata, exp_rdata);
        check_eq({tag, ".err"}, 32'(access_err), 32'(exp_err));
    endtask

    initial begin
        int cnt0;
        pre_we = 1'b0; pre_idx = 0; pre_data = '0; mem_rdata = '0;
        rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
        req_signed = 1'b0; req_addr = 32'h100; req_wdata = '0;

        repeat (3) @(negedge clk);
        check_eq("rst.ready", 32'(req_ready), 32'd1);
        check_eq("rst.strobes", {30'h0, mem_read, mem_write}, 32'h0);
        check_eq("rst.mem_addr", 32'(mem_addr), 32'h0);
        check_eq("rst.resp_cnt", 32'(resp_cnt), 32'd0);
        req_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        txn("st_word", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 3, 32'h0, 1'b0);
        check_eq("st_word.write", 32'(rec_write[1]), 32'd1);
        check_eq("st_word.read", 32'(rec_read[1]), 32'd0);
        check_eq("st_word.addr", 32'(rec_addr[1]), 32'h40);
        check_eq("st_word.be", 32'(rec_be[1]), 32'hF);
        check_eq("st_word.wdata", rec_wdata[1], 32'hDEADBEEF);
        check_eq("st_word.busy", 32'(rec_ready[1]), 32'd0);
        check_eq("st_word.idle2", {30'h0, rec_read[2], rec_write[2]}, 32'h0);
        check_eq("st_word.mem", mem[32'h40], 32'hDEADBEEF);

        txn("ld_word", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b0);
        check_eq("ld_word.read", 32'(rec_read[1]), 32'd1);

        poke(32'h40, 32'h80FF0000);
        txn("ld_sb103", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 3, 32'hFFFFFF80, 1'b0);
        check_eq("ld_sb103.be", 32'(rec_be[1]), 32'h8);
        txn("ld_ub103", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 3, 32'h00000080, 1'b0);
        txn("ld_sh102", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 3, 32'hFFFF80FF, 1'b0);
        txn("ld_sb102", 1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 3, 32'hFFFFFFFF, 1'b0);
        txn("ld_uh100", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 3, 32'h00000000, 1'b0);
        txn("ld_w_sgn", 1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 3, 32'h80FF0000, 1'b0);

        poke(32'h40, 32'h44332211);
        poke(32'h41, 32'h88776655);
        poke(1, 32'h11111111);
        poke(2, 32'h22222222);
        poke(MEM_WORDS - 1, 32'hA1B2C3D4);
        poke(0, 32'h55667788);
`ifdef LSU_MISALIGN_SPLIT_EN
        txn("ld_split", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 4, 32'h66554433, 1'b0);
        check_eq("ld_split.addr1", 32'(rec_addr[1]), 32'h40);
        check_eq("ld_split.addr2", 32'(rec_addr[2]), 32'h41);
        check_eq("ld_split.be1", 32'(rec_be[1]), 32'hC);
        check_eq("ld_split.be2", 32'(rec_be[2]), 32'h3);
        check_eq("ld_split.rd2", 32'(rec_read[2]), 32'd1);

        txn("st_split", 1'b1, 2'b01, 1'b0, 32'h7, 32'h0000ABCD, 4, 32'h0, 1'b0);
        check_eq("st_split.addr1", 32'(rec_addr[1]), 32'h1);
        check_eq("st_split.be1", 32'(rec_be[1]), 32'h8);
        check_eq("st_split.wd1", rec_wdata[1], 32'hCD000000);
        check_eq("st_split.addr2", 32'(rec_addr[2]), 32'h2);
        check_eq("st_split.be2", 32'(rec_be[2]), 32'h1);
        check_eq("st_split.wd2", rec_wdata[2], 32'h000000AB);
        check_eq("st_split.mem1", mem[1], 32'hCD111111);
        check_eq("st_split.mem2", mem[2], 32'h222222AB);

        txn("ld_wrap", 1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, 4, 32'h7788A1B2, 1'b0);
        check_eq("ld_wrap.addr1", 32'(rec_addr[1]), 32'h3FFFFFFF);
        check_eq("ld_wrap.addr2", 32'(rec_addr[2]), 32'h0);

        poke(1, 32'h0);
        poke(2, 32'h0);
        send(1'b1, 2'b01, 1'b0, 32'h7, 32'h00001234);
        @(negedge clk);
        check_eq("rst_mid.issue0", 32'(mem_write), 32'd1);
        @(posedge clk);
        #2 check_eq("rst_mid.issue1", 32'(mem_addr), 32'h2);
        rst_n = 1'b0;
        #1 check_eq("rst_mid.strobes", {30'h0, mem_read, mem_write}, 32'h0);
        check_eq("rst_mid.mem1", mem[1], 32'h34000000);
`else
        txn("ld_split", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 2, 32'h0, 1'b1);
        check_eq("ld_split.nostrobe", {28'h0, rec_read[1], rec_write[1], rec_read[2], rec_write[2]},
                 32'h0);

        txn("st_split", 1'b1, 2'b01, 1'b0, 32'h7, 32'h0000ABCD, 2, 32'h0, 1'b1);
        check_eq("st_split.mem1", mem[1], 32'h11111111);
        check_eq("st_split.mem2", mem[2], 32'h22222222);

        txn("ld_wrap", 1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, 2, 32'h0, 1'b1);

        poke(4, 32'h0);
        send(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D);
        #2 check_eq("rst_mid.issue0", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1 check_eq("rst_mid.strobes", {30'h0, mem_read, mem_write}, 32'h0);
        @(posedge clk);
        #1 check_eq("rst_mid.mem4", mem[4], 32'h0);
`endif
        cnt0 = resp_cnt;
        check_eq("rst_mid.ready_low", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("rst_mid.no_resp", 32'(resp_cnt), 32'(cnt0));
        check_eq("rst_mid.ready", 32'(req_ready), 32'd1);
`ifdef LSU_MISALIGN_SPLIT_EN
        check_eq("rst_mid.mem2", mem[2], 32'h0);
`endif

        txn("rsvd", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 2, 32'h0, 1'b1);
        check_eq("rsvd.nostrobe", {28'h0, rec_read[1], rec_write[1], rec_read[2], rec_write[2]},
                 32'h0);
        check_eq("rsvd.ready", 32'(rec_ready[2]), 32'd1);

        txn("ld_after", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 3, 32'h00000022, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
